// File: rtl/conv1d_stream_pkg.sv
// Shared types and helpers for the streaming 1-D convolution engine.
package conv1d_stream_pkg;

    // Control FSM states; the encoding is visible on the state_o debug port.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PAD   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Width of the intermediate used for clamping; wide enough for any sane accumulator.
    localparam int SatWidth = 64;

    // Full-precision accumulator width: one product plus growth for summing all taps.
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Clamp a signed value into the range of a signed out_w-bit result.
    function automatic logic signed [SatWidth-1:0] saturate(
        input logic signed [SatWidth-1:0] value,
        input int                         out_w
    );
        logic signed [SatWidth-1:0] hi;
        logic signed [SatWidth-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/conv1d_stream_mac.sv
// Combinational multiply-accumulate: per-tap products, sum, floor shift, saturation.
module conv1d_stream_mac
    import conv1d_stream_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int CoeffWidth = 16,
    parameter int NumTaps    = 8,
    parameter int OutWidth   = 16
) (
    input  logic [NumTaps*DataWidth-1:0]  win_i,
    input  logic [NumTaps*CoeffWidth-1:0] coeff_i,
    input  logic [4:0]                    shift_i,
    output logic [OutWidth-1:0]           result_o
);

    localparam int AccWidth = acc_width(DataWidth, CoeffWidth, NumTaps);

    logic signed [AccWidth-1:0] prod [NumTaps];
    logic signed [AccWidth-1:0] sum;
    logic signed [AccWidth-1:0] shifted;

    // Operands are sign-extended to accumulator width before multiplying so no bits are lost.
    for (genvar k = 0; k < NumTaps; k++) begin : g_prod
        logic signed [AccWidth-1:0] x_ext;
        logic signed [AccWidth-1:0] c_ext;
        assign x_ext   = AccWidth'($signed(win_i[k*DataWidth +: DataWidth]));
        assign c_ext   = AccWidth'($signed(coeff_i[k*CoeffWidth +: CoeffWidth]));
        assign prod[k] = x_ext * c_ext;
    end

    // Sum all tap products at full precision.
    always_comb begin
        sum = '0;
        for (int k = 0; k < NumTaps; k++) begin
            sum = sum + prod[k];
        end
    end

    // Arithmetic shift floors toward minus infinity; then clamp to the output range.
    assign shifted  = sum >>> shift_i;
    assign result_o = OutWidth'(saturate(SatWidth'(shifted), OutWidth));

endmodule

// File: rtl/conv1d_stream.sv
// Streaming NumTaps-tap FIR with run-time stride, "same" padding and output shift.
// Handshake rule on both streams: a transfer happens on a rising clock edge where
// valid and ready are both high; the producer keeps valid and data stable until then.
module conv1d_stream
    import conv1d_stream_pkg::*;
#(
    parameter int DataWidth  = 16,
    parameter int CoeffWidth = 16,
    parameter int NumTaps    = 8,
    parameter int OutWidth   = 16,
    parameter int LenWidth   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic [LenWidth-1:0]        len_i,
    input  logic [3:0]                 stride_i,
    input  logic                       pad_i,
    input  logic [4:0]                 shift_i,
    input  logic                       coeff_we_i,
    input  logic [$clog2(NumTaps)-1:0] coeff_idx_i,
    input  logic [CoeffWidth-1:0]      coeff_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [DataWidth-1:0]       in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [OutWidth-1:0]        out_data_o,
    output logic                       busy_o,
    output logic                       done_int_o,
    input  logic                       done_clr_i,
    output logic [2:0]                 state_o
);

    localparam int FillWidth = $clog2(NumTaps + 1);
    localparam logic [FillWidth-1:0] FillFull = FillWidth'(NumTaps);
    localparam logic [FillWidth-1:0] PadLast  = FillWidth'(NumTaps - 2);

    state_e                        state_q, state_d;
    logic [CoeffWidth-1:0]         coeff_q [NumTaps];
    logic [NumTaps*CoeffWidth-1:0] coeff_flat;
    logic [NumTaps*DataWidth-1:0]  win_q, win_shifted;
    logic [FillWidth-1:0]          fill_q, fill_inc;
    logic [3:0]                    phase_q, phase_inc, stride_q;
    logic [4:0]                    shift_q;
    logic [LenWidth-1:0]           len_q, cnt_q;
    logic                          out_valid_q, done_q;
    logic [OutWidth-1:0]           out_data_q, mac_result;
    logic                          accept, start_go, last_sample, window_full, emit;

    for (genvar k = 0; k < NumTaps; k++) begin : g_coeff_flat
        assign coeff_flat[k*CoeffWidth +: CoeffWidth] = coeff_q[k];
    end

    // Newest sample enters the top slot; slot 0 holds the oldest.
    assign win_shifted = {in_data_i, win_q[NumTaps*DataWidth-1:DataWidth]};
    assign fill_inc    = (fill_q == FillFull) ? FillFull : fill_q + FillWidth'(1);
    assign window_full = (fill_inc == FillFull);
    assign phase_inc   = ((phase_q + 4'd1) >= stride_q) ? 4'd0 : phase_q + 4'd1;
    assign start_go    = start_i && (state_q == ST_IDLE);
    assign in_ready_o  = (state_q == ST_RUN) && !(out_valid_q && !out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign last_sample = (cnt_q == len_q - LenWidth'(1));
    assign emit        = accept && window_full && (phase_q == 4'd0);
    assign busy_o      = (state_q != ST_IDLE);
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign done_int_o  = done_q;
    assign state_o     = state_q;

    conv1d_stream_mac #(
        .DataWidth (DataWidth),
        .CoeffWidth(CoeffWidth),
        .NumTaps   (NumTaps),
        .OutWidth  (OutWidth)
    ) u_mac (
        .win_i   (win_shifted),
        .coeff_i (coeff_flat),
        .shift_i (shift_q),
        .result_o(mac_result)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = (len_i == '0) ? ST_DONE : (pad_i ? ST_PAD : ST_RUN);
            ST_PAD:   if (fill_q == PadLast) state_d = ST_RUN;
            ST_RUN:   if (accept && last_sample) state_d = ST_DRAIN;
            ST_DRAIN: if (!out_valid_q) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Coefficients only change while idle so a run always sees one consistent kernel.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumTaps; k++) coeff_q[k] <= '0;
        end else if (coeff_we_i && (state_q == ST_IDLE)) begin
            coeff_q[coeff_idx_i] <= coeff_i;
        end
    end

    // Run configuration, window and counters: cleared at start, advanced on pad cycles and accepted samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            len_q    <= '0;
            stride_q <= 4'd1;
            shift_q  <= '0;
            win_q    <= '0;
            fill_q   <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
        end else if (start_go) begin
            len_q    <= len_i;
            stride_q <= (stride_i == 4'd0) ? 4'd1 : stride_i;
            shift_q  <= shift_i;
            win_q    <= '0;
            fill_q   <= '0;
            phase_q  <= '0;
            cnt_q    <= '0;
        end else if (state_q == ST_PAD) begin
            win_q  <= {{DataWidth{1'b0}}, win_q[NumTaps*DataWidth-1:DataWidth]};
            fill_q <= fill_inc;
        end else if (accept) begin
            win_q  <= win_shifted;
            fill_q <= fill_inc;
            cnt_q  <= cnt_q + LenWidth'(1);
            if (window_full) phase_q <= phase_inc;
        end
    end

    // Single output register: loaded by a qualifying sample, emptied when the consumer takes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_data_q  <= mac_result;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completion interrupt: setting on DONE takes priority over clear and start.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                         done_q <= 1'b0;
        else if (state_q == ST_DONE)       done_q <= 1'b1;
        else if (done_clr_i || start_go)   done_q <= 1'b0;
    end

endmodule

// File: tb/tb_conv1d_stream.sv
// Bench for conv1d_stream with NumTaps=4: directed test-plan cases plus random runs
// compared against an arithmetic reference model of the convolution.
module tb_conv1d_stream;

    localparam int NT = 4;
    localparam int DW = 16;
    localparam int CW = 16;
    localparam int OW = 16;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic [3:0]    stride_i = '0;
    logic          pad_i = 1'b0;
    logic [4:0]    shift_i = '0;
    logic          coeff_we_i = 1'b0;
    logic [1:0]    coeff_idx_i = '0;
    logic [CW-1:0] coeff_i = '0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] in_data_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b1;
    logic [OW-1:0] out_data_o;
    logic          busy_o;
    logic          done_int_o;
    logic          done_clr_i = 1'b0;
    logic [2:0]    state_o;

    conv1d_stream #(
        .DataWidth(DW), .CoeffWidth(CW), .NumTaps(NT), .OutWidth(OW), .LenWidth(LW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .stride_i(stride_i), .pad_i(pad_i), .shift_i(shift_i),
        .coeff_we_i(coeff_we_i), .coeff_idx_i(coeff_idx_i), .coeff_i(coeff_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .busy_o(busy_o), .done_int_o(done_int_o), .done_clr_i(done_clr_i),
        .state_o(state_o)
    );

    // Clock.
    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [OW-1:0] exp_q[$];
    logic [OW-1:0] got_q[$];
    int            xs[$];
    int            cf[NT];
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: collects transfers and checks the held-register rules.
    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid_o), 64'd1);
                check("hold_data", 64'(out_data_o), 64'(prev_data));
            end
            if (out_valid_o && !out_ready_i) check("ready_low_when_full", 64'(in_ready_o), 64'd0);
            if (out_valid_o && out_ready_i) got_q.push_back(out_data_o);
            prev_stall <= out_valid_o && !out_ready_i;
            prev_data  <= out_data_o;
        end
    end

    // Reference: list every full window, keep every stride-th one, floor-shift and clamp.
    task automatic model(input int len, input int stride, input bit pad, input int shift);
        int     seq[$];
        int     st;
        longint y;
        longint r;
        exp_q.delete();
        if (len == 0) return;
        st = (stride == 0) ? 1 : stride;
        if (pad) for (int i = 0; i < NT - 1; i++) seq.push_back(0);
        for (int i = 0; i < len; i++) seq.push_back(xs[i]);
        for (int i = NT - 1; i < seq.size(); i += st) begin
            y = 0;
            for (int k = 0; k < NT; k++) y += longint'(cf[k]) * longint'(seq[i - NT + 1 + k]);
            r = y >>> shift;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
            exp_q.push_back(OW'(r));
        end
    endtask

    task automatic write_coeffs();
        for (int k = 0; k < NT; k++) begin
            @(posedge clk); #1;
            coeff_we_i  = 1'b1;
            coeff_idx_i = 2'(k);
            coeff_i     = CW'(cf[k]);
        end
        @(posedge clk); #1;
        coeff_we_i = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: ready low for 5 cycles mid-run with dense input.
    task automatic run_case(input int len, input int stride, input bit pad, input int shift,
                            input int mode, input bit busy_write, input string tag);
        int idx;
        int cyc;
        bit acc;
        model(len, stride, pad, shift);
        got_q.delete();
        @(posedge clk); #1;
        start_i  = 1'b1;
        len_i    = LW'(len);
        stride_i = 4'(stride);
        pad_i    = pad;
        shift_i  = 5'(shift);
        @(posedge clk); #1;
        start_i = 1'b0;
        check({tag, "_done_cleared_by_start"}, 64'(done_int_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd1);
        if (pad && len > 0) begin
            for (int i = 0; i < NT - 1; i++) begin
                check({tag, "_pad_ready_low"}, 64'(in_ready_o), 64'd0);
                @(posedge clk); #1;
            end
            check({tag, "_ready_after_pad"}, 64'(in_ready_o), 64'd1);
        end
        idx = 0;
        cyc = 0;
        while (busy_o && cyc < 3000) begin
            if (busy_write && cyc == 0) begin
                coeff_we_i  = 1'b1;
                coeff_idx_i = 2'd0;
                coeff_i     = 16'd100;
            end else begin
                coeff_we_i = 1'b0;
            end
            case (mode)
                1:       out_ready_i = 1'($urandom_range(0, 1));
                2:       out_ready_i = !(cyc >= 6 && cyc < 11);
                default: out_ready_i = 1'b1;
            endcase
            in_valid_i = (idx < len) && ((mode == 2) || ($urandom_range(0, 3) != 0));
            in_data_i  = (idx < len) ? DW'(xs[idx]) : '0;
            @(negedge clk);
            acc = in_valid_i && in_ready_o;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        coeff_we_i  = 1'b0;
        check({tag, "_finished_in_budget"}, 64'(cyc < 3000), 64'd1);
        check({tag, "_all_samples_taken"}, 64'(idx), 64'(len));
        check({tag, "_done_int"}, 64'(done_int_o), 64'd1);
        check({tag, "_out_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, "_out_data"}, 64'(got_q[i]), 64'(exp_q[i]));
        done_clr_i = 1'b1;
        @(posedge clk); #1;
        done_clr_i = 1'b0;
        check({tag, "_done_clr"}, 64'(done_int_o), 64'd0);
    endtask

    task automatic set_ramp(input int n);
        xs.delete();
        for (int i = 1; i <= n; i++) xs.push_back(i);
    endtask

    task automatic set_cf(input int v);
        for (int k = 0; k < NT; k++) cf[k] = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready_o), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid_o), 64'd0);
        check({tag, "_out_data"}, 64'(out_data_o), 64'd0);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_done_int"}, 64'(done_int_o), 64'd0);
        check({tag, "_state"}, 64'(state_o), 64'd0);
    endtask

    initial begin
        // Power-on reset.
        rst_i = 1'b1;
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst_i = 1'b0;

        // Coefficients come out of reset as zero.
        set_cf(0);
        set_ramp(4);
        run_case(4, 1, 1'b0, 0, 0, 1'b0, "coeff_reset");

        // Main function with the all-ones kernel; coefficient writes while busy must be ignored.
        set_cf(1);
        write_coeffs();
        set_ramp(8);
        run_case(8, 1, 1'b0, 0, 0, 1'b1, "valid_s1");
        run_case(8, 2, 1'b0, 0, 0, 1'b0, "valid_s2");
        run_case(8, 0, 1'b0, 0, 0, 1'b0, "valid_s0");
        run_case(8, 1, 1'b1, 0, 0, 1'b0, "pad_s1");
        run_case(8, 3, 1'b1, 0, 1, 1'b0, "pad_s3_rnd");
        run_case(8, 1, 1'b0, 0, 2, 1'b0, "backpressure");
        run_case(8, 1, 1'b0, 0, 1, 1'b0, "rand_ready");

        // Saturation and rounding.
        set_cf(32767);
        write_coeffs();
        xs.delete();
        for (int i = 0; i < NT; i++) xs.push_back(32767);
        run_case(4, 1, 1'b0, 0, 0, 1'b0, "sat_pos");
        set_cf(-32768);
        write_coeffs();
        run_case(4, 1, 1'b0, 0, 0, 1'b0, "sat_neg");
        set_cf(1);
        write_coeffs();
        set_ramp(4);
        run_case(4, 1, 1'b0, 20, 0, 1'b0, "shift20");
        cf[0] = 1; cf[1] = 0; cf[2] = 0; cf[3] = 0;
        write_coeffs();
        xs.delete();
        xs.push_back(-1); xs.push_back(0); xs.push_back(0); xs.push_back(0);
        run_case(4, 1, 1'b0, 1, 0, 1'b0, "floor_neg");

        // Length corner cases.
        set_cf(1);
        write_coeffs();
        set_ramp(8);
        run_case(0, 1, 1'b0, 0, 0, 1'b0, "len0");
        run_case(0, 1, 1'b1, 0, 0, 1'b0, "len0_pad");
        run_case(3, 1, 1'b0, 0, 0, 1'b0, "len3_valid");

        // Reset in the middle of a run.
        @(posedge clk); #1;
        start_i  = 1'b1;
        len_i    = LW'(8);
        stride_i = 4'd1;
        pad_i    = 1'b0;
        shift_i  = 5'd0;
        @(posedge clk); #1;
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = DW'(xs[i]);
            @(posedge clk); #1;
        end
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midrun_rst");
        in_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        got_q.delete();
        repeat (10) @(posedge clk);
        #1;
        check("after_rst_no_output", 64'(got_q.size()), 64'd0);
        check("after_rst_no_irq", 64'(done_int_o), 64'd0);
        check("after_rst_idle", 64'(busy_o), 64'd0);
        write_coeffs();
        run_case(8, 1, 1'b0, 0, 0, 1'b0, "after_rst_run");

        // Randomised runs.
        for (int t = 0; t < 24; t++) begin
            for (int k = 0; k < NT; k++)
                cf[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                    : int'($urandom_range(0, 8)) - 4;
            write_coeffs();
            xs.delete();
            for (int i = 0; i < 20; i++)
                xs.push_back(($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                         : int'($urandom_range(0, 200)) - 100);
            run_case(int'($urandom_range(0, 20)), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 20)), int'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
